arith_unit: RTL and testbench
=============================

# arith_unit

Arithmetic unit (AU) datapath. It holds the three working registers A (accumulator), B (operand) and C (multiplier/quotient). It executes the single-cycle micro-operation pulses issued by the local program sensor (arith_ctrl) and returns sign and overflow levels to it. It sits directly downstream of arith_ctrl, and it exchanges words with memory through B (load) and A (store). Numbers are one's-complement: the MSB is the sign bit and the remaining bits are magnitude.

## Interface
Parameters:
- WIDTH, 31, word width. Bit WIDTH-1 is the sign; bits WIDTH-2..0 are magnitude.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- do_clear_a_to_au, do_clear_b_to_au, do_clear_c_to_au  in  1 each  pulses: zero the named register.
- do_not_a_to_au, do_not_b_to_au  in  1 each  pulses: bitwise invert A / B.
- do_sum_to_au  in  1  pulse: A <= A + B, one's-complement with end-around carry.
- do_and_to_au  in  1  pulse: A <= A & B.
- do_set_c_30_to_au  in  1  pulse: set C[0], the lowest digit (digit 30).
- do_left_shift_b_to_au  in  1  pulse: B <= {B[W-2:0],0}.
- do_left_shift_c_to_au  in  1  pulse: C <= {C[W-2:0],0}.
- do_left_shift_c29_to_au  in  1  pulse: C <= {C[W-1],C[W-3:0],0}; sign is held and only the magnitude shifts.
- do_right_shift_bc_to_au  in  1  pulse: 2W-bit right shift of {B,C}. B[W-1] is replicated; B[0] enters C[W-1]; C[0] is lost.
- do_move_c_to_a_to_au, do_move_c_to_b_to_au, do_move_b_to_c_to_au  in  1 each  pulses: copy between registers.
- load_b_from_mem  in  1  pulse: B <= mem_data_in.
- mem_data_in  in  WIDTH  word read from memory.
- reg_a_out  out  WIDTH  A contents; the memory store data.
- reg_b_out, reg_c_out  out  WIDTH  B and C contents, for the console and debug.
- reg_a_sign, reg_b_sign, reg_c_sign  out  1 each  MSB of each register.
- overflow_to_ctrl  out  1  sticky overflow level.
- a_zero  out  1  high when A is all-0 or all-1 (±0).

## Operation
- Every pulse lasts one cycle and takes effect at the next edge. All operations in a cycle read pre-edge register values.
  - Example: move_b_to_c and move_c_to_b in the same cycle swap B and C.
- Sum:
  - s = {1'b0,A} + {1'b0,B} (W+1 bits); result = s[W-1:0] + s[W], truncated to W bits.
  - Overflow is set when A[W-1]==B[W-1] and result[W-1]!=A[W-1].
  - Subtraction is do_not_b followed by do_sum; it is sequenced by arith_ctrl, not here.
- overflow_to_ctrl is sticky. It is set only by do_sum and cleared only by do_clear_a or reset. When do_clear_a and do_sum coincide, clear wins for both A and overflow.
- Per-register priority when several writers pulse in one cycle (highest first):
  - A: clear > move_c_to_a > not_a > sum > and.
  - B: clear > load_b_from_mem > move_c_to_b > not_b > left_shift_b > right_shift_bc.
  - C: clear > move_b_to_c > set_c_30 > left_shift_c > left_shift_c29 > right_shift_bc.
  - arith_ctrl never issues conflicting pulses. This priority fixes the behaviour regardless.
- When right_shift_bc and set_c_30 coincide, only set_c_30 writes C; B still shifts.
- Negative zero (all ones) is a legal value. a_zero covers both zeros, and no normalisation is performed.
- All outputs are registered state or direct decodes of it; there are no combinational paths from the do_* inputs.

## Timing
- Reset (asynchronous, active-low): A=B=C=0, overflow_to_ctrl=0, all signs=0, a_zero=1.
- Latency is one cycle: a pulse at edge n is visible on the outputs after edge n+1.
- Back-to-back pulses on consecutive cycles chain, each using the previous result. Throughput is one op per register per cycle.
- Deasserting resetn mid-sequence clears state immediately, independent of clk. Pulses in the reset-release cycle are honoured normally.
- mem_data_in is sampled only on the edge where load_b_from_mem=1.
- The end-around carry completes within the same cycle; there is no multicycle path.

## Test plan
- Reset: hold resetn low, pulse do_sum -> A=B=C=0, overflow=0, a_zero=1. Release, then load B=0x00000005 -> reg_b_out=5 one cycle later.
- Add/subtract: A=5, B=3, do_sum -> A=8. Then B=3, do_not_b (B=0x7FFFFFFC), A=5, do_sum -> A=2 via end-around carry; overflow stays 0.
- Overflow: A=0x3FFFFFFF, B=1, do_sum -> A=0x40000000, overflow=1. A further do_sum keeps overflow=1; do_clear_a -> A=0, overflow=0.
- Shifts: B=0x40000001, C=0x00000002, right_shift_bc -> B=0x60000000, C=0x40000001. C=0x40000001, left_shift_c29 -> C=0x40000002. C=0x3FFFFFFF, left_shift_c -> C=0x7FFFFFFE.
- Swap: B=0x11, C=0x22, move_b_to_c and move_c_to_b in the same cycle -> B=0x22, C=0x11. Then move_c_to_a -> A=0x11.
- Priority and negative zero: do_clear_c with set_c_30 -> C=0. A=0x7FFFFFFF -> a_zero=1, reg_a_sign=1. do_and with B=0x0F -> A=0x0F.

Source files
------------

// File: rtl/arith_unit.sv
// Arithmetic unit datapath: accumulator A, operand B and multiplier/quotient C.
// Executes one-cycle micro-operation pulses from the program sensor using
// one's-complement arithmetic, and reports sign, overflow and zero status.
module arith_unit #(
   parameter int WIDTH = 31
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             do_clear_a_to_au,
   input  logic             do_clear_b_to_au,
   input  logic             do_clear_c_to_au,
   input  logic             do_not_a_to_au,
   input  logic             do_not_b_to_au,
   input  logic             do_sum_to_au,
   input  logic             do_and_to_au,
   input  logic             do_set_c_30_to_au,
   input  logic             do_left_shift_b_to_au,
   input  logic             do_left_shift_c_to_au,
   input  logic             do_left_shift_c29_to_au,
   input  logic             do_right_shift_bc_to_au,
   input  logic             do_move_c_to_a_to_au,
   input  logic             do_move_c_to_b_to_au,
   input  logic             do_move_b_to_c_to_au,
   input  logic             load_b_from_mem,
   input  logic [WIDTH-1:0] mem_data_in,
   output logic [WIDTH-1:0] reg_a_out,
   output logic [WIDTH-1:0] reg_b_out,
   output logic [WIDTH-1:0] reg_c_out,
   output logic             reg_a_sign,
   output logic             reg_b_sign,
   output logic             reg_c_sign,
   output logic             overflow_to_ctrl,
   output logic             a_zero
);

   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [WIDTH-1:0]   c;
   logic               overflow;
   logic [WIDTH:0]     sum_raw;
   logic [WIDTH-1:0]   sum_res;
   logic               sum_ovf;
   logic [2*WIDTH-1:0] bc_shift;

   // One's-complement adder: the carry out of the MSB wraps back into bit 0.
   always_comb begin
      sum_raw  = {1'b0, a} + {1'b0, b};
      sum_res  = sum_raw[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, sum_raw[WIDTH]};
      sum_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_res[WIDTH-1] != a[WIDTH-1]);
      bc_shift = {b[WIDTH-1], b, c[WIDTH-1:1]};
   end

   // Accumulator and sticky overflow; clearing A also clears the overflow flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a        <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_clear_a_to_au)          a <= '0;
         else if (do_move_c_to_a_to_au) a <= c;
         else if (do_not_a_to_au)       a <= ~a;
         else if (do_sum_to_au)         a <= sum_res;
         else if (do_and_to_au)         a <= a & b;

         if (do_clear_a_to_au)                overflow <= 1'b0;
         else if (do_sum_to_au && sum_ovf)    overflow <= 1'b1;
      end
   end

   // Operand register B: memory load port and upper half of the BC shifter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         b <= '0;
      end else begin
         if (do_clear_b_to_au)              b <= '0;
         else if (load_b_from_mem)          b <= mem_data_in;
         else if (do_move_c_to_b_to_au)     b <= c;
         else if (do_not_b_to_au)           b <= ~b;
         else if (do_left_shift_b_to_au)    b <= {b[WIDTH-2:0], 1'b0};
         else if (do_right_shift_bc_to_au)  b <= bc_shift[2*WIDTH-1:WIDTH];
      end
   end

   // Multiplier/quotient register C: digit setting, shifts and lower half of BC.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         c <= '0;
      end else begin
         if (do_clear_c_to_au)               c <= '0;
         else if (do_move_b_to_c_to_au)      c <= b;
         else if (do_set_c_30_to_au)         c <= c | {{(WIDTH-1){1'b0}}, 1'b1};
         else if (do_left_shift_c_to_au)     c <= {c[WIDTH-2:0], 1'b0};
         else if (do_left_shift_c29_to_au)   c <= {c[WIDTH-1], c[WIDTH-3:0], 1'b0};
         else if (do_right_shift_bc_to_au)   c <= bc_shift[WIDTH-1:0];
      end
   end

   assign reg_a_out        = a;
   assign reg_b_out        = b;
   assign reg_c_out        = c;
   assign reg_a_sign       = a[WIDTH-1];
   assign reg_b_sign       = b[WIDTH-1];
   assign reg_c_sign       = c[WIDTH-1];
   assign overflow_to_ctrl = overflow;
   assign a_zero           = (~|a) | (&a);

endmodule

// File: tb/tb_arith_unit.sv
// Scoreboard bench for arith_unit: stimulus pushes predicted register state
// from an arithmetic reference model, a monitor pops and compares each cycle.
module tb_arith_unit;

   localparam int W = 31;
   typedef logic [W-1:0] word_t;
   localparam longint MASK    = (longint'(1) << W) - 1;
   localparam longint MAGMASK = (longint'(1) << (W-1)) - 1;
   localparam longint SIGNBIT = longint'(1) << (W-1);

   localparam logic [15:0] OP_CLR_A  = 16'h0001;
   localparam logic [15:0] OP_CLR_B  = 16'h0002;
   localparam logic [15:0] OP_CLR_C  = 16'h0004;
   localparam logic [15:0] OP_NOT_A  = 16'h0008;
   localparam logic [15:0] OP_NOT_B  = 16'h0010;
   localparam logic [15:0] OP_SUM    = 16'h0020;
   localparam logic [15:0] OP_AND    = 16'h0040;
   localparam logic [15:0] OP_SETC   = 16'h0080;
   localparam logic [15:0] OP_LSB    = 16'h0100;
   localparam logic [15:0] OP_LSC    = 16'h0200;
   localparam logic [15:0] OP_LSC29  = 16'h0400;
   localparam logic [15:0] OP_RSBC   = 16'h0800;
   localparam logic [15:0] OP_MV_CA  = 16'h1000;
   localparam logic [15:0] OP_MV_CB  = 16'h2000;
   localparam logic [15:0] OP_MV_BC  = 16'h4000;
   localparam logic [15:0] OP_LOAD   = 16'h8000;

   typedef struct packed {
      word_t a;
      word_t b;
      word_t c;
      logic  ovf;
   } exp_t;

   logic        clk;
   logic        resetn;
   logic [15:0] op;
   word_t       mem_data;
   word_t       reg_a_out, reg_b_out, reg_c_out;
   logic        reg_a_sign, reg_b_sign, reg_c_sign;
   logic        overflow_to_ctrl, a_zero;

   int   assertCount = 0;
   int   failCount   = 0;
   exp_t expQ[$];
   word_t ma, mb, mc;
   logic  movf;

   arith_unit #(.WIDTH(W)) dut (
      .clk                     (clk),
      .resetn                  (resetn),
      .do_clear_a_to_au        (op[0]),
      .do_clear_b_to_au        (op[1]),
      .do_clear_c_to_au        (op[2]),
      .do_not_a_to_au          (op[3]),
      .do_not_b_to_au          (op[4]),
      .do_sum_to_au            (op[5]),
      .do_and_to_au            (op[6]),
      .do_set_c_30_to_au       (op[7]),
      .do_left_shift_b_to_au   (op[8]),
      .do_left_shift_c_to_au   (op[9]),
      .do_left_shift_c29_to_au (op[10]),
      .do_right_shift_bc_to_au (op[11]),
      .do_move_c_to_a_to_au    (op[12]),
      .do_move_c_to_b_to_au    (op[13]),
      .do_move_b_to_c_to_au    (op[14]),
      .load_b_from_mem         (op[15]),
      .mem_data_in             (mem_data),
      .reg_a_out               (reg_a_out),
      .reg_b_out               (reg_b_out),
      .reg_c_out               (reg_c_out),
      .reg_a_sign              (reg_a_sign),
      .reg_b_sign              (reg_b_sign),
      .reg_c_sign              (reg_c_sign),
      .overflow_to_ctrl        (overflow_to_ctrl),
      .a_zero                  (a_zero)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input word_t act, input word_t exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One's-complement addition: values live modulo 2^W - 1.
   function automatic word_t onesAdd(input word_t x, input word_t y);
      longint s;
      s = longint'(x) + longint'(y);
      if (s > MASK) s = s - MASK;
      return word_t'(s);
   endfunction

   function automatic logic isNeg(input word_t x);
      return longint'(x) >= SIGNBIT;
   endfunction

   // Advance the reference model by one operation and record the prediction.
   task automatic modelIssue(input logic [15:0] o, input word_t d);
      word_t  na, nb, nc, sumv, rsB, rsC;
      logic   novf;
      longint bc;
      sumv = onesAdd(ma, mb);
      bc   = (longint'(mb) << W) | longint'(mc);
      bc   = bc >> 1;
      if (isNeg(mb)) bc = bc | (longint'(1) << (2*W-1));
      rsB  = word_t'(bc >> W);
      rsC  = word_t'(bc & MASK);

      na = ma;
      if ((o & OP_CLR_A) != 0)      na = '0;
      else if ((o & OP_MV_CA) != 0) na = mc;
      else if ((o & OP_NOT_A) != 0) na = word_t'(MASK - longint'(ma));
      else if ((o & OP_SUM) != 0)   na = sumv;
      else if ((o & OP_AND) != 0)   na = ma & mb;

      novf = movf;
      if ((o & OP_CLR_A) != 0) novf = 1'b0;
      else if ((o & OP_SUM) != 0 && isNeg(ma) == isNeg(mb) && isNeg(sumv) != isNeg(ma))
         novf = 1'b1;

      nb = mb;
      if ((o & OP_CLR_B) != 0)      nb = '0;
      else if ((o & OP_LOAD) != 0)  nb = d;
      else if ((o & OP_MV_CB) != 0) nb = mc;
      else if ((o & OP_NOT_B) != 0) nb = word_t'(MASK - longint'(mb));
      else if ((o & OP_LSB) != 0)   nb = word_t'((longint'(mb) * 2) & MASK);
      else if ((o & OP_RSBC) != 0)  nb = rsB;

      nc = mc;
      if ((o & OP_CLR_C) != 0)       nc = '0;
      else if ((o & OP_MV_BC) != 0)  nc = mb;
      else if ((o & OP_SETC) != 0)   nc = mc | word_t'(1);
      else if ((o & OP_LSC) != 0)    nc = word_t'((longint'(mc) * 2) & MASK);
      else if ((o & OP_LSC29) != 0)
         nc = word_t'((longint'(mc) & SIGNBIT) | (((longint'(mc) & MAGMASK) * 2) & MAGMASK));
      else if ((o & OP_RSBC) != 0)   nc = rsC;

      ma = na; mb = nb; mc = nc; movf = novf;
      expQ.push_back('{a: na, b: nb, c: nc, ovf: novf});
   endtask

   task automatic applyStimulus(input logic [15:0] o, input word_t d);
      @(negedge clk);
      op       = o;
      mem_data = d;
      modelIssue(o, d);
   endtask

   task automatic goIdle();
      @(negedge clk);
      op       = '0;
      mem_data = $urandom & word_t'(MASK);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (expQ.size() > 0 && guard < 20) begin
         @(posedge clk);
         #2;
         guard++;
      end
      if (expQ.size() > 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
      end
   endtask

   // Monitor: after every edge with a pending prediction, compare the registers.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("sb_a", reg_a_out, e.a);
            checkOutput("sb_b", reg_b_out, e.b);
            checkOutput("sb_c", reg_c_out, e.c);
            checkOutput("sb_ovf", word_t'(overflow_to_ctrl), word_t'(e.ovf));
            checkOutput("sb_azero", word_t'(a_zero),
                        word_t'(e.a == '0 || longint'(e.a) == MASK));
            checkOutput("sb_signs", word_t'({reg_a_sign, reg_b_sign, reg_c_sign}),
                        word_t'({isNeg(e.a), isNeg(e.b), isNeg(e.c)}));
         end
      end
   end

   // Stimulus: reset, directed scenarios, randomized traffic, mid-run reset.
   initial begin
      logic [15:0] r;
      op       = OP_SUM;
      mem_data = word_t'(31'h0000_0005);
      resetn   = 1'b0;
      ma = '0; mb = '0; mc = '0; movf = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_a", reg_a_out, '0);
      checkOutput("rst_b", reg_b_out, '0);
      checkOutput("rst_c", reg_c_out, '0);
      checkOutput("rst_ovf", word_t'(overflow_to_ctrl), '0);
      checkOutput("rst_azero", word_t'(a_zero), word_t'(1));
      @(negedge clk);
      resetn = 1'b1;
      op     = '0;

      applyStimulus(OP_LOAD, 31'h0000_0005);
      settle(); checkOutput("load_b5", reg_b_out, 31'h0000_0005);

      applyStimulus(OP_CLR_A | OP_LOAD, 31'h5);
      applyStimulus(OP_SUM, '0);
      applyStimulus(OP_LOAD, 31'h3);
      applyStimulus(OP_SUM, '0);
      settle(); checkOutput("add_5_3", reg_a_out, 31'h8);

      applyStimulus(OP_CLR_A | OP_LOAD, 31'h5);
      applyStimulus(OP_SUM, '0);
      applyStimulus(OP_LOAD, 31'h3);
      applyStimulus(OP_NOT_B, '0);
      settle(); checkOutput("not_b3", reg_b_out, 31'h7FFF_FFFC);
      applyStimulus(OP_SUM, '0);
      settle(); checkOutput("sub_5_3", reg_a_out, 31'h2);
      checkOutput("sub_ovf", word_t'(overflow_to_ctrl), '0);

      applyStimulus(OP_CLR_A | OP_LOAD, 31'h3FFF_FFFF);
      applyStimulus(OP_SUM, '0);
      applyStimulus(OP_LOAD, 31'h1);
      applyStimulus(OP_SUM, '0);
      settle(); checkOutput("ovf_sum", reg_a_out, 31'h4000_0000);
      checkOutput("ovf_set", word_t'(overflow_to_ctrl), word_t'(1));
      applyStimulus(OP_SUM, '0);
      settle(); checkOutput("ovf_sticky", word_t'(overflow_to_ctrl), word_t'(1));
      applyStimulus(OP_CLR_A | OP_SUM, '0);
      settle(); checkOutput("ovf_clr_a", reg_a_out, '0);
      checkOutput("ovf_clr", word_t'(overflow_to_ctrl), '0);

      applyStimulus(OP_LOAD, 31'h2);
      applyStimulus(OP_MV_BC, '0);
      applyStimulus(OP_LOAD, 31'h4000_0001);
      applyStimulus(OP_RSBC, '0);
      settle(); checkOutput("rsbc_b", reg_b_out, 31'h6000_0000);
      checkOutput("rsbc_c", reg_c_out, 31'h4000_0001);
      applyStimulus(OP_LSC29, '0);
      settle(); checkOutput("lsc29", reg_c_out, 31'h4000_0002);
      applyStimulus(OP_LOAD, 31'h3FFF_FFFF);
      applyStimulus(OP_MV_BC, '0);
      applyStimulus(OP_LSC, '0);
      settle(); checkOutput("lsc", reg_c_out, 31'h7FFF_FFFE);

      applyStimulus(OP_LOAD, 31'h22);
      applyStimulus(OP_MV_BC, '0);
      applyStimulus(OP_LOAD, 31'h11);
      applyStimulus(OP_MV_BC | OP_MV_CB, '0);
      settle(); checkOutput("swap_b", reg_b_out, 31'h22);
      checkOutput("swap_c", reg_c_out, 31'h11);
      applyStimulus(OP_MV_CA, '0);
      settle(); checkOutput("mv_c_a", reg_a_out, 31'h11);

      applyStimulus(OP_CLR_C | OP_SETC, '0);
      settle(); checkOutput("clr_c_prio", reg_c_out, '0);
      applyStimulus(OP_CLR_A | OP_LOAD, 31'h7FFF_FFFF);
      applyStimulus(OP_SUM, '0);
      settle(); checkOutput("negzero_a", reg_a_out, 31'h7FFF_FFFF);
      checkOutput("negzero_azero", word_t'(a_zero), word_t'(1));
      checkOutput("negzero_sign", word_t'(reg_a_sign), word_t'(1));
      applyStimulus(OP_LOAD, 31'h0F);
      applyStimulus(OP_AND, '0);
      settle(); checkOutput("and_0f", reg_a_out, 31'h0F);
      applyStimulus(OP_RSBC | OP_SETC, '0);
      applyStimulus(OP_LOAD | OP_NOT_B | OP_LSB, 31'h1234);

      for (int i = 0; i < 400; i++) begin
         r = '0;
         for (int k = 0; k < 16; k++)
            if ($urandom_range(0, 5) == 0) r[k] = 1'b1;
         if ((r & (OP_MV_CA | OP_NOT_A)) != 0) r = r & ~OP_SUM;
         applyStimulus(r, word_t'($urandom & 32'h7FFF_FFFF));
      end

      goIdle();
      drain();
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("async_rst_a", reg_a_out, '0);
      checkOutput("async_rst_b", reg_b_out, '0);
      checkOutput("async_rst_c", reg_c_out, '0);
      checkOutput("async_rst_ovf", word_t'(overflow_to_ctrl), '0);
      ma = '0; mb = '0; mc = '0; movf = 1'b0;
      @(negedge clk);
      resetn   = 1'b1;
      op       = OP_LOAD;
      mem_data = 31'h0000_1234;
      modelIssue(OP_LOAD, 31'h0000_1234);
      settle(); checkOutput("release_load", reg_b_out, 31'h0000_1234);
      goIdle();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
